// File: rtl/du_line_tx_sequencer_pkg.sv
// Shared definitions for the line transmit sequencer slice.
//   - Calculator symbol codes and their width (shared with the display/arithmetic side).
//   - ASCII control characters appended to every transmitted line.
//   - FSM state encoding of the sequencer.
package du_line_tx_sequencer_pkg;

    localparam int DAU_SYM_WIDTH = 5;
    typedef logic [DAU_SYM_WIDTH-1:0] dau_sym_t;

    // Digits occupy codes 0..9 so the ASCII digit is {4'h3, code[3:0]}.
    localparam dau_sym_t DAU_SYM_0     = 5'h00;
    localparam dau_sym_t DAU_SYM_1     = 5'h01;
    localparam dau_sym_t DAU_SYM_2     = 5'h02;
    localparam dau_sym_t DAU_SYM_3     = 5'h03;
    localparam dau_sym_t DAU_SYM_4     = 5'h04;
    localparam dau_sym_t DAU_SYM_5     = 5'h05;
    localparam dau_sym_t DAU_SYM_6     = 5'h06;
    localparam dau_sym_t DAU_SYM_7     = 5'h07;
    localparam dau_sym_t DAU_SYM_8     = 5'h08;
    localparam dau_sym_t DAU_SYM_9     = 5'h09;
    // Operator range: low nibble equals the low nibble of the ASCII glyph
    // (0x2B '+', 0x2C ',', 0x2D '-'), so the byte is {4'h2, code[3:0]}.
    localparam dau_sym_t DAU_SYM_PLUS  = 5'h1B;
    localparam dau_sym_t DAU_SYM_MINUS = 5'h1D;
    localparam dau_sym_t DAU_SYM_BLANK = 5'h1F;

    localparam logic [7:0] DU_CHAR_CR   = 8'h0D;
    localparam logic [7:0] DU_CHAR_LF   = 8'h0A;
    localparam logic [7:0] DU_CHAR_NONE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT_SYM,
        ST_EMIT_CR,
        ST_EMIT_LF
    } tx_state_t;

endpackage

// File: rtl/du_line_tx_sequencer_if.sv
// Symbol-in / byte-out bus of the line transmit sequencer.
//   i_sym_valid/i_symbol/o_sym_ready : symbol offer into the line buffer
//   i_line_end                       : single-cycle line commit strobe
//   o_char_valid/o_char/i_char_ready : ASCII byte stream to the UART sink
//   o_busy, o_overflow               : status
// master = symbol producer + byte sink side, slave = the sequencer.
interface du_line_tx_sequencer_if;
    import du_line_tx_sequencer_pkg::*;

    logic       i_sym_valid;
    dau_sym_t   i_symbol;
    logic       o_sym_ready;
    logic       i_line_end;
    logic       o_char_valid;
    logic [7:0] o_char;
    logic       i_char_ready;
    logic       o_busy;
    logic       o_overflow;

    modport master (
        output i_sym_valid, i_symbol, i_line_end, i_char_ready,
        input  o_sym_ready, o_char_valid, o_char, o_busy, o_overflow
    );

    modport slave (
        input  i_sym_valid, i_symbol, i_line_end, i_char_ready,
        output o_sym_ready, o_char_valid, o_char, o_busy, o_overflow
    );
endinterface

// File: rtl/du_sym_to_ascii_char.sv
// Combinational symbol-to-ASCII converter.
//   sym   : calculator symbol code
//   ascii : printable byte, or 0x00 when the symbol has no glyph
module du_sym_to_ascii_char
    import du_line_tx_sequencer_pkg::*;
(
    input  dau_sym_t   sym,
    output logic [7:0] ascii
);
    always_comb begin
        ascii = DU_CHAR_NONE;
        if (sym <= DAU_SYM_9)
            ascii = {4'h3, sym[3:0]};
        else if (sym >= DAU_SYM_PLUS && sym <= DAU_SYM_MINUS)
            ascii = {4'h2, sym[3:0]};
    end
endmodule

// File: rtl/du_line_tx_sequencer.sv
// Line transmit sequencer: collects symbols into a line buffer, and on a
// line-end strobe streams them as ASCII bytes followed by CR LF.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : symbol input, commit strobe, byte output, busy/overflow
module du_line_tx_sequencer
    import du_line_tx_sequencer_pkg::*;
#(
    parameter int LINE_DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    du_line_tx_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(LINE_DEPTH + 1);
    localparam int IDX_W = $clog2(LINE_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LINE_DEPTH);

    dau_sym_t         line_buf [LINE_DEPTH];
    tx_state_t        state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rd_next;
    logic [CNT_W-1:0] count_wr;
    logic             sym_acc;
    logic             char_valid_q;
    logic [7:0]       char_q;
    logic             busy_q;
    logic             overflow_q;
    logic [7:0]       conv;

    assign bus.o_sym_ready  = !i_rst && state == ST_IDLE && count < DEPTH_C;
    assign bus.o_char_valid = char_valid_q;
    assign bus.o_char       = char_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_overflow   = overflow_q;

    assign sym_acc  = bus.i_sym_valid && bus.o_sym_ready;
    // Count including a symbol written in the commit cycle itself.
    assign count_wr = count + CNT_W'(sym_acc);
    assign rd_next  = rd_ptr + CNT_W'(1);

    du_sym_to_ascii_char u_conv (
        .sym   (line_buf[rd_ptr[IDX_W-1:0]]),
        .ascii (conv)
    );

    // Line storage carries no reset: count alone says what is valid.
    always_ff @(posedge i_clk) begin
        if (sym_acc)
            line_buf[count[IDX_W-1:0]] <= bus.i_symbol;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            char_valid_q <= 1'b0;
            char_q       <= DU_CHAR_NONE;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    count <= count_wr;
                    if (bus.i_sym_valid && count == DEPTH_C)
                        overflow_q <= 1'b1;
                    if (bus.i_line_end) begin
                        busy_q <= 1'b1;
                        rd_ptr <= '0;
                        if (count_wr == '0) begin
                            char_q       <= DU_CHAR_CR;
                            char_valid_q <= 1'b1;
                            state        <= ST_EMIT_CR;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_ptr <= rd_next;
                    if (conv == DU_CHAR_NONE) begin
                        // Unmapped symbol: drop it; CR directly if it was the last.
                        if (rd_next >= count) begin
                            char_q       <= DU_CHAR_CR;
                            char_valid_q <= 1'b1;
                            state        <= ST_EMIT_CR;
                        end
                    end else begin
                        char_q       <= conv;
                        char_valid_q <= 1'b1;
                        state        <= ST_EMIT_SYM;
                    end
                end
                ST_EMIT_SYM: begin
                    if (bus.i_char_ready) begin
                        if (rd_ptr < count) begin
                            char_valid_q <= 1'b0;
                            state        <= ST_FETCH;
                        end else begin
                            // Last symbol: CR follows with no bubble.
                            char_q <= DU_CHAR_CR;
                            state  <= ST_EMIT_CR;
                        end
                    end
                end
                ST_EMIT_CR: begin
                    if (bus.i_char_ready) begin
                        char_q <= DU_CHAR_LF;
                        state  <= ST_EMIT_LF;
                    end
                end
                ST_EMIT_LF: begin
                    if (bus.i_char_ready) begin
                        char_valid_q <= 1'b0;
                        count        <= '0;
                        rd_ptr       <= '0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_du_line_tx_sequencer.sv
module tb_du_line_tx_sequencer;
    import du_line_tx_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    du_line_tx_sequencer_if bus ();

    du_line_tx_sequencer #(.LINE_DEPTH(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, and checks that a
    // pending byte stays valid and unchanged until it is taken.
    logic       pend = 1'b0;
    logic [7:0] pend_char = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend)
                chk("hold_stable", {23'd0, bus.o_char_valid, bus.o_char}, {23'd0, 1'b1, pend_char});
            if (bus.o_char_valid && bus.i_char_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h want none", bus.o_char);
                end else begin
                    chk("sb_byte", {24'd0, bus.o_char}, {24'd0, exp_q.pop_front()});
                end
                pend <= 1'b0;
            end else if (bus.o_char_valid) begin
                pend      <= 1'b1;
                pend_char <= bus.o_char;
            end else begin
                pend <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input dau_sym_t s);
        bus.i_sym_valid = 1'b1;
        bus.i_symbol    = s;
        step();
        bus.i_sym_valid = 1'b0;
    endtask

    task automatic commit();
        bus.i_line_end = 1'b1;
        step();
        bus.i_line_end = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_within_budget", {31'd0, n < 200}, 32'd1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_sym_valid  = 1'b0;
        bus.i_symbol     = DAU_SYM_0;
        bus.i_line_end   = 1'b0;
        bus.i_char_ready = 1'b1;

        // Reset state
        repeat (2) step();
        chk("rst_char_valid", {31'd0, bus.o_char_valid}, 32'd0);
        chk("rst_char",       {24'd0, bus.o_char},       32'h00);
        chk("rst_busy",       {31'd0, bus.o_busy},       32'd0);
        chk("rst_overflow",   {31'd0, bus.o_overflow},   32'd0);
        chk("rst_sym_ready",  {31'd0, bus.o_sym_ready},  32'd0);
        rst = 1'b0;
        #1;
        chk("sym_ready_after_rst", {31'd0, bus.o_sym_ready}, 32'd1);

        // 1 2 + line, sink always ready
        push_sym(DAU_SYM_1);
        push_sym(DAU_SYM_2);
        push_sym(DAU_SYM_PLUS);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h2B);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        chk("fetch_bubble_valid", {31'd0, bus.o_char_valid}, 32'd0);
        chk("busy_after_commit",  {31'd0, bus.o_busy},       32'd1);
        step();
        chk("first_byte_valid", {31'd0, bus.o_char_valid}, 32'd1);
        chk("first_byte",       {24'd0, bus.o_char},       32'h31);
        wait_idle();
        chk("busy_dropped", {31'd0, bus.o_busy},      32'd0);
        chk("ready_again",  {31'd0, bus.o_sym_ready}, 32'd1);

        // Empty line: CR one cycle after commit
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        chk("empty_cr_valid", {31'd0, bus.o_char_valid}, 32'd1);
        chk("empty_cr",       {24'd0, bus.o_char},       32'h0D);
        wait_idle();

        // Full buffer and overflow
        for (int i = 0; i < 16; i++) begin
            push_sym(dau_sym_t'(i % 10));
            exp_q.push_back(8'h30 + 8'(i % 10));
        end
        chk("full_sym_ready", {31'd0, bus.o_sym_ready}, 32'd0);
        chk("full_no_ovf",    {31'd0, bus.o_overflow},  32'd0);
        push_sym(DAU_SYM_9);
        chk("ovf_set",         {31'd0, bus.o_overflow},  32'd1);
        chk("ovf_sym_ready",   {31'd0, bus.o_sym_ready}, 32'd0);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        wait_idle();
        chk("ovf_cleared", {31'd0, bus.o_overflow}, 32'd0);

        // Backpressure on a single symbol
        bus.i_char_ready = 1'b0;
        push_sym(DAU_SYM_7);
        exp_q.push_back(8'h37); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, bus.o_char_valid}, 32'd1);
            chk("bp_char",  {24'd0, bus.o_char},       32'h37);
            if (k < 4) step();
        end
        bus.i_char_ready = 1'b1;
        step();
        chk("bp_cr_next_valid", {31'd0, bus.o_char_valid}, 32'd1);
        chk("bp_cr_next",       {24'd0, bus.o_char},       32'h0D);
        wait_idle();

        // Unmapped symbol in the middle is skipped
        push_sym(DAU_SYM_5);
        push_sym(5'h0A);
        push_sym(DAU_SYM_9);
        exp_q.push_back(8'h35); exp_q.push_back(8'h39);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        wait_idle();

        // Reset while a symbol byte is pending
        bus.i_char_ready = 1'b0;
        push_sym(DAU_SYM_3);
        push_sym(DAU_SYM_4);
        commit();
        step();
        chk("pre_rst_valid", {31'd0, bus.o_char_valid}, 32'd1);
        chk("pre_rst_char",  {24'd0, bus.o_char},       32'h33);
        rst = 1'b1;
        step();
        chk("midrst_valid",     {31'd0, bus.o_char_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, bus.o_busy},       32'd0);
        chk("midrst_sym_ready", {31'd0, bus.o_sym_ready},  32'd0);
        rst = 1'b0;
        #1;
        chk("postrst_sym_ready", {31'd0, bus.o_sym_ready}, 32'd1);
        // A fresh line must carry only the new symbol, proving count was cleared.
        bus.i_char_ready = 1'b1;
        push_sym(DAU_SYM_2);
        exp_q.push_back(8'h32); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        commit();
        wait_idle();

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
